// File: rtl/affine_x_mul.sv
// rtl/affine_x_mul.sv - bit-serial affine x = X * Z^-1 mod (2^255 - 19)
module affine_x_mul #(
    parameter logic [254:0] P_MOD = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [254:0] x_in,
    input  logic [254:0] z_inv,
    input  logic         inv_valid,
    output logic [254:0] x_aff,
    output logic         x_valid,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic         inv_valid_d;
    logic [255:0] acc;
    logic [254:0] a;
    logic [254:0] b;
    logic [7:0]   cnt;

    logic         trigger;
    logic [254:0] a_load;
    logic [255:0] p_ext;
    logic [255:0] t_raw;
    logic [255:0] t_red;
    logic [255:0] u_raw;
    logic [255:0] u_red;

    assign trigger = inv_valid & ~inv_valid_d;
    assign p_ext   = {1'b0, P_MOD};

    // One double-and-add step; acc and a stay below p so a single
    // conditional subtract after each add keeps the result reduced.
    always_comb begin
        a_load = (x_in >= P_MOD) ? (x_in - P_MOD) : x_in;
        t_raw  = acc << 1;
        t_red  = (t_raw >= p_ext) ? (t_raw - p_ext) : t_raw;
        u_raw  = t_red + (b[cnt] ? {1'b0, a} : 256'd0);
        u_red  = (u_raw >= p_ext) ? (u_raw - p_ext) : u_raw;
    end

    // Control FSM and datapath registers; triggers outside IDLE are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            inv_valid_d <= 1'b0;
            acc         <= 256'd0;
            a           <= 255'd0;
            b           <= 255'd0;
            cnt         <= 8'd0;
            x_aff       <= 255'd0;
            x_valid     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            inv_valid_d <= inv_valid;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        a       <= a_load;
                        b       <= z_inv;
                        acc     <= 256'd0;
                        cnt     <= 8'd254;
                        busy    <= 1'b1;
                        x_valid <= 1'b0;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    acc <= u_red;
                    if (cnt == 8'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    x_aff   <= acc[254:0];
                    x_valid <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
